contrast_stretch_accel: RTL and testbench

Memory-side initiator for the single-port 32-bit image RAM. It performs a two-pass, power-of-two contrast stretch on a 352x288 8-bit grayscale image held as 25344 little-endian packed words at addresses 0..25343. It writes the result to addresses 25344..50687 and then raises `finish`, which the top level connects to the RAM's `dump_image`.

---
 rtl/accel_pkg.sv | 13 +
 rtl/contrast_stretch_accel_if.sv | 13 +
 rtl/minmax4.sv | 19 +
 rtl/contrast_stretch_accel.sv | 85 ++++++++
 tb/tb_contrast_stretch_accel.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: shared constants, FSM states and shift helper for the contrast stretch accelerator
package accel_pkg;
  localparam int IMG_WORDS = 25344;
  localparam int ADDR_W = 16;
  localparam int PIX_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CALC, RD, WR, DONE} state_t;
  // Left shift that brings the MSB of the range up to bit 7; a zero range gets no shift.
  function automatic logic [2:0] shift_of(input logic [7:0] r);
    shift_of = 3'd0;
    for (int k = 0; k < 8; k++)
      if (r[k]) shift_of = 3'(7 - k);
  endfunction
endpackage

// File: rtl/contrast_stretch_accel_if.sv
// contrast_stretch_accel_if: start/finish handshake plus single-port image RAM bus
interface contrast_stretch_accel_if;
  import accel_pkg::*;
  logic start;
  logic finish;
  logic en;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [31:0] dataW;
  logic [31:0] dataR;
  modport master (input start, dataR, output finish, en, we, addr, dataW);
  modport slave (output start, dataR, input finish, en, we, addr, dataW);
endinterface

// File: rtl/minmax4.sv
// minmax4: folds the four bytes of a packed word into a running min/max
module minmax4
  import accel_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  mn,
  input  logic [7:0]  mx,
  output logic [7:0]  new_mn,
  output logic [7:0]  new_mx
);
  always_comb begin
    new_mn = mn;
    new_mx = mx;
    for (int j = 0; j < PIX_PER_WORD; j++) begin
      new_mn = word[8*j+:8] < new_mn ? word[8*j+:8] : new_mn;
      new_mx = word[8*j+:8] > new_mx ? word[8*j+:8] : new_mx;
    end
  end
endmodule

// File: rtl/contrast_stretch_accel.sv
// contrast_stretch_accel: two-pass power-of-two contrast stretch over the packed image RAM
module contrast_stretch_accel #(
  parameter int IMG_WORDS = accel_pkg::IMG_WORDS
) (
  input  logic clk,
  input  logic reset,
  contrast_stretch_accel_if.master bus
);
  import accel_pkg::*;
  localparam logic [14:0] LAST = 15'(IMG_WORDS - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(IMG_WORDS);
  state_t state, next;
  logic [14:0] i;
  logic [7:0] mn, mx, fold_mn, fold_mx;
  logic [2:0] s;
  logic last;
  logic [31:0] stretched;
  assign last = i == LAST;
  minmax4 u_fold (
    .word(bus.dataR),
    .mn(mn),
    .mx(mx),
    .new_mn(fold_mn),
    .new_mx(fold_mx)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // A SCAN cycle folds the word read in the cycle before, so i==0 has nothing to fold yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      i  <= '0;
      mn <= 8'hff;
      mx <= '0;
      s  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          i  <= '0;
          mn <= 8'hff;
          mx <= '0;
        end
        SCAN: begin
          if (!last) i <= i + 15'd1;
          if (i != '0) begin
            mn <= fold_mn;
            mx <= fold_mx;
          end
        end
        DRAIN: begin
          mn <= fold_mn;
          mx <= fold_mx;
        end
        CALC: begin
          s <= shift_of(mx - mn);
          i <= '0;
        end
        WR: if (!last) i <= i + 15'd1;
        default: ;
      endcase
    end
  end
  always_comb begin
    stretched = '0;
    for (int j = 0; j < PIX_PER_WORD; j++)
      stretched[8*j+:8] = 8'((bus.dataR[8*j+:8] - mn) << s);
  end
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = bus.start ? SCAN : state;
      SCAN:       next = last ? DRAIN : SCAN;
      DRAIN:      next = CALC;
      CALC:       next = RD;
      RD:         next = WR;
      WR:         next = last ? DONE : RD;
      default:    next = IDLE;
    endcase
  end
  assign bus.en     = state == SCAN || state == RD || state == WR;
  assign bus.we     = state == WR;
  assign bus.addr   = state == WR ? OUT_BASE + ADDR_W'(i) :
                      (state == SCAN || state == RD) ? ADDR_W'(i) : '0;
  assign bus.dataW  = state == WR ? stretched : '0;
  assign bus.finish = state == DONE;
endmodule

// File: tb/tb_contrast_stretch_accel.sv
// tb_contrast_stretch_accel: random images through a read-first RAM model, checked against a reference stretch
module tb_contrast_stretch_accel;
  localparam int N = 128;
  localparam int LAT = 3 * N + 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [2*N];
  logic [31:0] img [N];
  contrast_stretch_accel_if bus ();
  contrast_stretch_accel #(.IMG_WORDS(N)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.en) begin
      bus.dataR <= mem[bus.addr[7:0]];
      if (bus.we) mem[bus.addr[7:0]] <= bus.dataW;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++)
        mem[k][8*j+:8] = 8'($urandom_range(hi, lo));
    mem[1][7:0] = 8'(lo);
    mem[N-1][31:24] = 8'(hi);
    for (int k = N; k < 2 * N; k++) mem[k] = 32'hdeadbeef;
  endtask

  task automatic kick();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_image(input string tag, input bit poke);
    int n, lo, hi, r, sh, p;
    logic [31:0] w;
    lo = 255;
    hi = 0;
    for (int k = 0; k < N; k++) begin
      img[k] = mem[k];
      for (int j = 0; j < 4; j++) begin
        p = int'(img[k][8*j+:8]);
        if (p < lo) lo = p;
        if (p > hi) hi = p;
      end
    end
    r = hi - lo;
    sh = 0;
    if (r > 0) while (r * (2 ** sh) < 128) sh++;
    kick();
    n = 0;
    while (n < LAT + 50) begin
      @(posedge clk);
      n++;
      #1;
      if (poke && n == 10) bus.start = 1'b1;
      if (poke && n == 11) bus.start = 1'b0;
      if (bus.finish) break;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    repeat (3) @(posedge clk);
    #1 chk({tag, " done hold"}, {29'd0, bus.finish, bus.en, bus.we}, 32'b100);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 4; j++)
        w[8*j+:8] = 8'((int'(img[k][8*j+:8]) - lo) * (2 ** sh));
      chk($sformatf("%s word %0d", tag, k), mem[N+k], w);
    end
  endtask

  initial begin
    int n, nwr;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset ctl", {29'd0, bus.finish, bus.en, bus.we}, 32'd0);
    chk("reset addr", 32'(bus.addr), 32'd0);
    chk("reset dataW", bus.dataW, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle ctl", {29'd0, bus.finish, bus.en, bus.we}, 32'd0);

    fill(128, 128);
    run_image("flat", 1'b0);
    chk("flat word0", mem[N], 32'h0);

    fill(10, 110);
    mem[0] = 32'h6e3c0a0a;
    run_image("r10_110", 1'b1);
    chk("r10_110 word0", mem[N], 32'hc8640000);

    fill(0, 255);
    run_image("full", 1'b0);
    chk("full copy", mem[N+5], mem[5]);

    fill(37, 38);
    mem[0] = 32'h26252625;
    run_image("r37_38", 1'b0);
    chk("r37_38 word0", mem[N], 32'h80008000);

    fill(1, 4);
    mem[0] = 32'h04030201;
    run_image("lanes", 1'b0);
    chk("lanes word0", mem[N], 32'hc0804000);

    n = $urandom_range(120, 0);
    fill(n, n + $urandom_range(135, 1));
    run_image("rand", 1'b0);

    fill(0, 255);
    kick();
    n = 0;
    nwr = 0;
    while (nwr < 100 && n < LAT) begin
      @(posedge clk);
      n++;
      #1 if (bus.we) nwr++;
    end
    chk("wr count", 32'(nwr), 32'd100);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("mid-wr reset ctl", {29'd0, bus.finish, bus.en, bus.we}, 32'd0);
    chk("mid-wr reset addr", 32'(bus.addr), 32'd0);
    @(posedge clk);
    #1 chk("reset hold ctl", {29'd0, bus.finish, bus.en, bus.we}, 32'd0);
    @(negedge clk) reset = 1'b0;
    n = $urandom_range(100, 0);
    fill(n, n + $urandom_range(150, 2));
    run_image("rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
